// File: rtl/present_feeder_if.sv
// Handshake/bus bundle between the byte-serial loader, the PRESENT core and
// the ciphertext consumer. The feeder connects through the master modport;
// the environment (source, core, sink) sees the slave modport.
interface present_feeder_if #(
    parameter int N_K = 80,
    parameter int N_B = 64
);
    // byte-serial load side
    logic [7:0]     din;
    logic           din_valid;
    logic           din_ready;
    logic           new_key;
    // encryption core side
    logic [N_K-1:0] k;
    logic [N_B-1:0] m;
    logic           req;
    logic           ack;
    logic [N_B-1:0] c;
    // result side
    logic [N_B-1:0] c_out;
    logic           c_valid;
    logic           c_ready;
    logic           err;

    modport master (
        input  din, din_valid, new_key, ack, c, c_ready,
        output din_ready, k, m, req, c_out, c_valid, err
    );

    modport slave (
        output din, din_valid, new_key, ack, c, c_ready,
        input  din_ready, k, m, req, c_out, c_valid, err
    );
endinterface

// File: rtl/present_feeder.sv
// present_feeder: collects a byte-serial frame (key bytes then message bytes,
// MSB first), holds k/m steady while requesting the PRESENT core, captures the
// ciphertext on ack (or reports a timeout) and offers it downstream.
// Optional feature macro KEY_REUSE_EN: when defined, a frame whose first byte
// arrives with new_key=0 carries only the message and reuses the stored key.
module present_feeder #(
    parameter int N_K     = 80,
    parameter int N_B     = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    present_feeder_if.master     bus
);
    localparam int KB = N_K / 8;              // key bytes in a full frame
    localparam int MB = N_B / 8;              // message bytes
    localparam int FB = KB + MB;              // full frame length
    localparam int CW = $clog2(FB + 1);       // byte counter never wraps inside a frame
    localparam int WW = $clog2(TIMEOUT + 1);  // wait counter reaches TIMEOUT-1 at most

    localparam logic [1:0] S_LOAD = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_OUT  = 2'd2;

    logic [1:0]     state_q,   state_d;
    logic [CW-1:0]  cnt_q,     cnt_d;
    logic [WW-1:0]  wait_q,    wait_d;
    logic [N_K-1:0] k_q,       k_d;
    logic [N_B-1:0] m_q,       m_d;
    logic           req_q,     req_d;
    logic [N_B-1:0] c_out_q,   c_out_d;
    logic           c_valid_q, c_valid_d;
    logic           err_q,     err_d;
    logic [CW-1:0]  eff_cnt;

`ifndef KEY_REUSE_EN
    // Port is kept for compatibility; every frame is a full key+message frame.
    logic unused_new_key;
    assign unused_new_key = bus.new_key;
`endif

    // Next-state logic: frame loading, core wait/timeout and output handshake.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        wait_d    = wait_q;
        k_d       = k_q;
        m_d       = m_q;
        req_d     = req_q;
        c_out_d   = c_out_q;
        c_valid_d = c_valid_q;
        err_d     = err_q;
        eff_cnt   = cnt_q;
        case (state_q)
            S_LOAD: begin
                // ack is ignored here; only accepted bytes change state
                if (bus.din_valid) begin
`ifdef KEY_REUSE_EN
                    // message-only frame: skip straight past the key bytes
                    if (cnt_q == '0 && !bus.new_key)
                        eff_cnt = CW'(KB);
`endif
                    if (eff_cnt < CW'(KB))
                        k_d = {k_q[N_K-9:0], bus.din};
                    else
                        m_d = {m_q[N_B-9:0], bus.din};
                    if (eff_cnt == CW'(FB - 1)) begin
                        cnt_d   = '0;
                        wait_d  = '0;
                        req_d   = 1'b1;
                        state_d = S_RUN;
                    end else begin
                        cnt_d = eff_cnt + 1'b1;
                    end
                end
            end
            S_RUN: begin
                // ack wins over a timeout landing in the same cycle
                if (bus.ack) begin
                    c_out_d   = bus.c;
                    err_d     = 1'b0;
                    req_d     = 1'b0;
                    c_valid_d = 1'b1;
                    wait_d    = '0;
                    state_d   = S_OUT;
                end else if (wait_q == WW'(TIMEOUT - 1)) begin
                    c_out_d   = '0;
                    err_d     = 1'b1;
                    req_d     = 1'b0;
                    c_valid_d = 1'b1;
                    wait_d    = '0;
                    state_d   = S_OUT;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
            end
            S_OUT: begin
                if (bus.c_ready) begin
                    c_valid_d = 1'b0;
                    cnt_d     = '0;
                    state_d   = S_LOAD;
                end
            end
            default: begin
                state_d = S_LOAD;
            end
        endcase
    end

    // State registers; reset clears everything immediately, dropping req mid-run.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_LOAD;
            cnt_q     <= '0;
            wait_q    <= '0;
            k_q       <= '0;
            m_q       <= '0;
            req_q     <= 1'b0;
            c_out_q   <= '0;
            c_valid_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            wait_q    <= wait_d;
            k_q       <= k_d;
            m_q       <= m_d;
            req_q     <= req_d;
            c_out_q   <= c_out_d;
            c_valid_q <= c_valid_d;
            err_q     <= err_d;
        end
    end

    // Not ready while reset is held so the first byte lands after the first edge.
    assign bus.din_ready = (state_q == S_LOAD) && !rst;
    assign bus.k         = k_q;
    assign bus.m         = m_q;
    assign bus.req       = req_q;
    assign bus.c_out     = c_out_q;
    assign bus.c_valid   = c_valid_q;
    assign bus.err       = err_q;
endmodule

// File: tb/tb_present_feeder.sv
// Directed bench for present_feeder with a behavioural PRESENT-80 core model.
module tb_present_feeder;
    localparam int LAT = 10;   // core model latency in cycles

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    present_feeder_if #(.N_K(80), .N_B(64)) bus ();

    present_feeder #(.N_K(80), .N_B(64), .TIMEOUT(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // ---------------- PRESENT-80 reference model ----------------
    function automatic logic [3:0] sbox(input logic [3:0] x);
        case (x)
            4'h0: sbox = 4'hC; 4'h1: sbox = 4'h5; 4'h2: sbox = 4'h6; 4'h3: sbox = 4'hB;
            4'h4: sbox = 4'h9; 4'h5: sbox = 4'h0; 4'h6: sbox = 4'hA; 4'h7: sbox = 4'hD;
            4'h8: sbox = 4'h3; 4'h9: sbox = 4'hE; 4'hA: sbox = 4'hF; 4'hB: sbox = 4'h8;
            4'hC: sbox = 4'h4; 4'hD: sbox = 4'h7; 4'hE: sbox = 4'h1; default: sbox = 4'h2;
        endcase
    endfunction

    function automatic logic [63:0] present80(input logic [79:0] key, input logic [63:0] pt);
        logic [63:0] s, t;
        logic [79:0] kr;
        s  = pt;
        kr = key;
        for (int r = 1; r <= 31; r++) begin
            s = s ^ kr[79:16];
            for (int j = 0; j < 16; j++) s[4*j +: 4] = sbox(s[4*j +: 4]);
            t = '0;
            for (int b = 0; b < 64; b++) t[(b == 63) ? 63 : ((b * 16) % 63)] = s[b];
            s  = t;
            kr = {kr[18:0], kr[79:19]};
            kr[79:76] = sbox(kr[79:76]);
            kr[19:15] = kr[19:15] ^ 5'(r);
        end
        present80 = s ^ kr[79:16];
    endfunction

    // ---------------- core model + spurious ack injection ----------------
    logic        ack_core = 1'b0;
    logic [63:0] c_core   = '0;
    int          lat      = 0;
    bit          core_en  = 1'b1;
    logic        spur_ack = 1'b0;
    logic [63:0] spur_c   = '0;

    assign bus.ack = ack_core | spur_ack;
    assign bus.c   = c_core | spur_c;

    always @(negedge clk) begin
        if (rst) begin
            ack_core = 1'b0; c_core = '0; lat = 0;
        end else if (ack_core) begin
            ack_core = 1'b0; c_core = '0; lat = 0;
        end else if (core_en && bus.req) begin
            if (lat == LAT) begin
                ack_core = 1'b1;
                c_core   = present80(bus.k, bus.m);
            end else begin
                lat++;
            end
        end else begin
            lat = 0;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic send_frame(input logic [79:0] key, input logic [63:0] msg,
                              input bit nk, input int nbytes, input bit gaps);
        logic [7:0] b;
        int t;
        for (int i = 0; i < nbytes; i++) begin
            if (gaps && i > 0) begin
                @(negedge clk);
                bus.din_valid = 1'b0;
                bus.din       = 8'h5A;
                spur_ack      = (i == 9);
                spur_c        = (i == 9) ? 64'h0123456789ABCDEF : 64'h0;
            end
            if (nbytes == 18 && i < 10) b = key[79 - 8*i -: 8];
            else                        b = msg[63 - 8*(i - (nbytes - 8)) -: 8];
            @(negedge clk);
            spur_ack      = 1'b0;
            spur_c        = '0;
            bus.din       = b;
            bus.din_valid = 1'b1;
            bus.new_key   = (i == 0) ? nk : ~nk;
            t = 0;
            while (!bus.din_ready && t < 300) begin @(negedge clk); t++; end
            checks++;
            if (t >= 300) begin errors++; $display("FAIL din_ready_wait: byte %0d never accepted", i); end
            @(posedge clk);
        end
        #1 bus.din_valid = 1'b0;
    endtask

    task automatic wait_cvalid(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (!bus.c_valid && t < 400) begin @(negedge clk); t++; end
        checks++;
        if (t >= 400) begin errors++; $display("FAIL %s_cvalid_timeout: c_valid never rose", name); end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (bus.req !== 1'b0)    begin errors++; $display("FAIL rst_req: got %b exp 0", bus.req); end
        checks++; if (bus.c_valid !== 1'b0) begin errors++; $display("FAIL rst_cvalid: got %b exp 0", bus.c_valid); end
        checks++; if (bus.err !== 1'b0)    begin errors++; $display("FAIL rst_err: got %b exp 0", bus.err); end
        checks++; if (bus.c_out !== 64'h0) begin errors++; $display("FAIL rst_cout: got %h exp 0", bus.c_out); end
        checks++; if (bus.k !== 80'h0 || bus.m !== 64'h0) begin errors++; $display("FAIL rst_km: got %h/%h exp 0/0", bus.k, bus.m); end
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.din_ready !== 1'b1) begin errors++; $display("FAIL rst_din_ready: got %b exp 1", bus.din_ready); end
    endtask

    task automatic test_basic();
        int nv;
        bus.c_ready = 1'b1;
        send_frame(80'h0, 64'h0, 1'b1, 18, 1'b0);
        @(negedge clk);
        checks++; if (bus.req !== 1'b1 || bus.din_ready !== 1'b0) begin errors++; $display("FAIL basic_run_entry: req=%b din_ready=%b exp 1/0", bus.req, bus.din_ready); end
        wait_cvalid("basic");
        checks++; if (bus.c_out !== 64'h5579C1387B228445) begin errors++; $display("FAIL basic_cout: got %h exp 5579C1387B228445", bus.c_out); end
        checks++; if (bus.err !== 1'b0 || bus.req !== 1'b0) begin errors++; $display("FAIL basic_err_req: err=%b req=%b exp 0/0", bus.err, bus.req); end
        nv = 0;
        while (bus.c_valid && nv < 10) begin nv++; @(negedge clk); end
        checks++; if (nv !== 1) begin errors++; $display("FAIL basic_one_cvalid: got %0d cycles exp 1", nv); end
        checks++; if (bus.din_ready !== 1'b1) begin errors++; $display("FAIL basic_back_to_load: din_ready=%b exp 1", bus.din_ready); end
    endtask

    task automatic test_hold();
        bus.c_ready = 1'b0;
        send_frame(80'hFFFFFFFFFFFFFFFFFFFF, 64'h0, 1'b1, 18, 1'b0);
        wait_cvalid("hold");
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (bus.c_valid !== 1'b1 || bus.c_out !== 64'hE72C46C0F5945049) begin
                errors++; $display("FAIL hold_cycle%0d: c_valid=%b c_out=%h exp 1/E72C46C0F5945049", i, bus.c_valid, bus.c_out);
            end
            @(negedge clk);
        end
        bus.c_ready = 1'b1;
        @(negedge clk);
        checks++; if (bus.c_valid !== 1'b0) begin errors++; $display("FAIL hold_release: c_valid=%b exp 0", bus.c_valid); end
    endtask

    task automatic test_new_key();
        bus.c_ready = 1'b1;
`ifdef KEY_REUSE_EN
        send_frame(80'h0, 64'h0, 1'b1, 18, 1'b0);
        wait_cvalid("reuse_first");
        checks++; if (bus.c_out !== 64'h5579C1387B228445) begin errors++; $display("FAIL reuse_first_cout: got %h exp 5579C1387B228445", bus.c_out); end
        @(negedge clk);
        send_frame(80'h0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 8, 1'b0);
        wait_cvalid("reuse_second");
        checks++; if (bus.c_out !== 64'hA112FFC72F68417B) begin errors++; $display("FAIL reuse_second_cout: got %h exp A112FFC72F68417B", bus.c_out); end
        checks++; if (bus.k !== 80'h0) begin errors++; $display("FAIL reuse_key_kept: got %h exp 0", bus.k); end
`else
        // new_key=0 must be ignored: a full 18-byte frame is still expected
        send_frame(80'h0, 64'hFFFFFFFFFFFFFFFF, 1'b0, 18, 1'b0);
        wait_cvalid("nokey");
        checks++; if (bus.c_out !== 64'hA112FFC72F68417B) begin errors++; $display("FAIL nokey_cout: got %h exp A112FFC72F68417B", bus.c_out); end
        checks++; if (bus.k !== 80'h0) begin errors++; $display("FAIL nokey_k: got %h exp 0", bus.k); end
`endif
        @(negedge clk);
    endtask

    task automatic test_gap();
        bus.c_ready = 1'b0;
        send_frame(80'h0, 64'h0, 1'b1, 18, 1'b1);
        @(negedge clk);
        checks++; if (bus.c_out !== 64'hA112FFC72F68417B) begin errors++; $display("FAIL gap_spurious_ack: c_out=%h exp A112FFC72F68417B", bus.c_out); end
        checks++; if (bus.req !== 1'b1 || bus.m !== 64'h0) begin errors++; $display("FAIL gap_run: req=%b m=%h exp 1/0", bus.req, bus.m); end
        wait_cvalid("gap");
        checks++; if (bus.c_out !== 64'h5579C1387B228445) begin errors++; $display("FAIL gap_cout: got %h exp 5579C1387B228445", bus.c_out); end
        bus.c_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        core_en     = 1'b0;
        bus.c_ready = 1'b0;
        send_frame(80'h123456789ABCDEF01234, 64'hFEDCBA9876543210, 1'b1, 18, 1'b0);
        n = 0;
        @(negedge clk);
        while (bus.req && n < 400) begin
            checks++;
            if (bus.k !== 80'h123456789ABCDEF01234 || bus.m !== 64'hFEDCBA9876543210) begin
                errors++; $display("FAIL to_km_stable: k=%h m=%h at run cycle %0d", bus.k, bus.m, n);
            end
            n++;
            @(negedge clk);
        end
        checks++; if (n !== 255) begin errors++; $display("FAIL to_req_cycles: got %0d exp 255", n); end
        checks++; if (bus.err !== 1'b1 || bus.c_out !== 64'h0 || bus.c_valid !== 1'b1) begin
            errors++; $display("FAIL to_result: err=%b c_out=%h c_valid=%b exp 1/0/1", bus.err, bus.c_out, bus.c_valid);
        end
        spur_ack = 1'b1;
        spur_c   = 64'hDEADBEEFCAFEF00D;
        @(negedge clk);
        spur_ack = 1'b0;
        spur_c   = '0;
        @(negedge clk);
        checks++; if (bus.err !== 1'b1 || bus.c_out !== 64'h0 || bus.c_valid !== 1'b1) begin
            errors++; $display("FAIL to_ack_in_out: err=%b c_out=%h c_valid=%b exp 1/0/1", bus.err, bus.c_out, bus.c_valid);
        end
        bus.c_ready = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_rst_run();
        core_en = 1'b0;
        send_frame(80'h0, 64'h0, 1'b1, 18, 1'b0);
        repeat (3) @(negedge clk);
        checks++; if (bus.req !== 1'b1) begin errors++; $display("FAIL rr_pre_req: got %b exp 1", bus.req); end
        #2 rst = 1'b1;
        #1;
        checks++; if (bus.req !== 1'b0 || bus.k !== 80'h0) begin errors++; $display("FAIL rr_async_drop: req=%b k=%h exp 0/0", bus.req, bus.k); end
        rst = 1'b0;
        core_en = 1'b1;
        send_frame(80'hFFFFFFFFFFFFFFFFFFFF, 64'hFFFFFFFFFFFFFFFF, 1'b1, 18, 1'b0);
        wait_cvalid("rr");
        checks++; if (bus.c_out !== 64'h3333DCD3213210D2 || bus.err !== 1'b0) begin
            errors++; $display("FAIL rr_cout: got %h err=%b exp 3333DCD3213210D2/0", bus.c_out, bus.err);
        end
    endtask

    initial begin
        bus.din       = 8'h0;
        bus.din_valid = 1'b0;
        bus.new_key   = 1'b1;
        bus.c_ready   = 1'b0;
        test_reset();
        test_basic();
        test_hold();
        test_new_key();
        test_gap();
        test_timeout();
        test_rst_run();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/present_feeder.md
PRESENT_FEEDER -- requirements
Module: present_feeder

Interface
REQ-001 Parameter N_K, default 80, key width in bits; shall equal `N_K from params.h.
REQ-002 Parameter N_B, default 64, block width in bits; shall equal `N_B from params.h.
REQ-003 Parameter TIMEOUT, default 255, maximum cycles in RUN waiting for ack before error.
REQ-004 clk  input  1  single clock; all state changes on its rising edge.
REQ-005 rst  input  1  reset, asynchronous, active-high.
REQ-006 din  input  8  byte-serial load data, most significant byte first.
REQ-007 din_valid  input  1  din carries a byte.
REQ-008 din_ready  output  1  feeder accepts din this cycle.
REQ-009 new_key  input  1  sampled with first byte of a frame; frame carries key (see Configuration).
REQ-010 k  output  N_K  key to encryption core.
REQ-011 m  output  N_B  plaintext to encryption core.
REQ-012 req  output  1  request to encryption core.
REQ-013 ack  input  1  completion strobe from encryption core.
REQ-014 c  input  N_B  ciphertext from encryption core, valid while ack=1.
REQ-015 c_out  output  N_B  captured ciphertext.
REQ-016 c_valid  output  1  c_out valid to downstream consumer.
REQ-017 c_ready  input  1  downstream accepts c_out.
REQ-018 err  output  1  last operation timed out; c_out=0 in that case.

Function
REQ-019 States: LOAD, RUN, OUT; encoding free.
REQ-020 LOAD: din_ready=1; byte accepted when din_valid=1; byte counter increments per accepted byte.
REQ-021 Full frame: 10 key bytes then 8 message bytes; first key byte lands in k[79:72], first message byte in m[63:56].
REQ-022 Cycle after last frame byte accepted: state=RUN, req=1; din_ready=0 in RUN and OUT.
REQ-023 k and m shall stay constant for the whole RUN state.
REQ-024 RUN: first cycle with ack=1 captures c into c_out, clears err, deasserts req next cycle, enters OUT.
REQ-025 RUN: wait counter increments per cycle without ack; after TIMEOUT cycles: req=0, c_out=0, err=1, enter OUT.
REQ-026 ack=1 in LOAD or OUT shall be ignored; no register changes.
REQ-027 OUT: c_valid=1; on c_ready=1 enter LOAD next cycle with byte counter=0, c_valid=0.
REQ-028 c_ready=1 on first OUT cycle gives exactly one c_valid cycle.
REQ-029 c_out and err hold their values until the next capture or timeout.
REQ-030 din_valid while din_ready=0 shall not be consumed; source holds the byte.
REQ-031 Byte and wait counters sized for 18 and TIMEOUT; no wrap inside a frame.

Reset
REQ-032 rst=1 forces immediately, regardless of clk: state=LOAD, counters=0, k=0, m=0, req=0, c_out=0, c_valid=0, err=0.
REQ-033 rst during RUN drops req in the same cycle; the partial frame is discarded.
REQ-034 din_ready=1 from the first clk edge after rst falls.

Configuration
REQ-035 Macro KEY_REUSE_EN.
REQ-036 Defined: new_key=1 on first byte selects 18-byte frame; new_key=0 selects 8-byte message-only frame reusing stored k.
REQ-037 Undefined: every frame is 18 bytes; new_key ignored; port kept.

Verification
REQ-038 Frame k=0, m=0, real core -> req held until ack; c_out=5579C1387B228445, c_valid=1, err=0.
REQ-039 Frame k=FFFFFFFFFFFFFFFFFFFF, m=0 -> c_out=E72C46C0F5945049; c_ready low 5 cycles -> c_valid held 5 cycles, c_out stable.
REQ-040 KEY_REUSE_EN: 18-byte frame k=0, m=0, then 8-byte frame (new_key=0) m=FFFFFFFFFFFFFFFF -> second c_out=A112FFC72F68417B.
REQ-041 Core stubbed, ack never asserted, TIMEOUT=255 -> req falls after 255 RUN cycles; err=1, c_out=0, c_valid=1.
REQ-042 rst pulsed mid-RUN -> req=0 without clock edge; next frame k=FF.., m=FF.. -> c_out=3333DCD3213210D2.
REQ-043 din_valid toggled every other cycle during LOAD, spurious ack in LOAD -> same c_out as gap-free frame; no early RUN.
